// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared state encodings and sizing helpers for the CAF FOA sequencer
package caf_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    LAST     = 3'd2,
    WAIT_RES = 3'd3,
    OUTPUT   = 3'd4
  } seq_state_t;

  // Index of the zero-Doppler bin in a symmetric bank of n_foas bins
  function automatic int centre_bin(input int n_foas);
    return (n_foas - 1) / 2;
  endfunction

  // Signed bin offsets need one bit more than the bin index
  function automatic int foa_off_bits(input int cnt_bits);
    return cnt_bits + 1;
  endfunction

endpackage

// File: rtl/caf_foa_step_map.sv
// rtl/caf_foa_step_map.sv - maps a signed bin offset d to (|d| * freq_res, sign)
module caf_foa_step_map #(
  parameter int phase_bits = 10,
  parameter int d_bits     = 4
) (
  input  logic signed [d_bits-1:0]     d,
  input  logic        [phase_bits-1:0] freq_res,
  output logic        [phase_bits-1:0] freq_step,
  output logic                         neg_shift
);

  logic [d_bits-1:0] mag;

  // Magnitude of the offset times the per-bin step, wrapping modulo 2**phase_bits
  always_comb begin
    neg_shift = d[d_bits-1];
    mag       = neg_shift ? -d : d;
    freq_step = phase_bits'(mag) * freq_res;
  end

endmodule

// File: rtl/caf_foa_sequencer.sv
// rtl/caf_foa_sequencer.sv - programs the CAF FOA bank and returns the peak as a signed offset; optional watchdog under CAF_FOA_SEQ_TIMEOUT_EN
module caf_foa_sequencer
  import caf_pkg::*;
#(
  parameter int phase_bits          = 10,
  parameter int foas                = 3,
  parameter int foas_counter_bits   = 3,
  parameter int length_counter_bits = 3,
  parameter int out_max_bits        = 64
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
  ,
  parameter int timeout_cycles      = 4096
`endif
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [phase_bits-1:0]                       freq_res,
  output logic                                        busy,
  output logic [phase_bits-1:0]                       freq_step,
  output logic                                        neg_shift,
  output logic                                        freq_step_valid,
  output logic                                        freq_step_ack,
  input  logic                                        caf_step_ready,
  input  logic [foas_counter_bits-1:0]                caf_step_index,
  input  logic                                        res_tvalid,
  output logic                                        res_tready,
  input  logic [out_max_bits-1:0]                     caf_out_max,
  input  logic [foas_counter_bits-1:0]                caf_foas_index,
  input  logic [length_counter_bits-1:0]              caf_time_index,
  output logic                                        result_valid,
  input  logic                                        result_ready,
  output logic [out_max_bits-1:0]                     result_max,
  output logic [foa_off_bits(foas_counter_bits)-1:0]  result_foa,
  output logic [length_counter_bits-1:0]              result_lag,
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
  output logic                                        timeout_err,
`endif
  output logic                                        index_err
);

  localparam int ow = foa_off_bits(foas_counter_bits);
  localparam logic [ow-1:0] centre_w = ow'(centre_bin(foas));
  localparam logic [foas_counter_bits-1:0] last_k = foas_counter_bits'(foas - 1);

`ifdef CAF_FOA_SEQ_TIMEOUT_EN
  localparam int tw = $clog2(timeout_cycles + 1);
  logic [tw-1:0] wd_cnt;
`endif

  seq_state_t                   state;
  logic [foas_counter_bits-1:0] k;
  logic [phase_bits-1:0]        res_q;
  logic [foas_counter_bits-1:0] map_k;
  logic [phase_bits-1:0]        map_res;
  logic [ow-1:0]                map_d;
  logic [phase_bits-1:0]        map_step;
  logic                         map_neg;

  assign freq_step_ack = (state == LOAD) & freq_step_valid & caf_step_ready;

  // Pick the bin (and step size) the step registers will present next cycle
  always_comb begin
    map_k   = k;
    map_res = res_q;
    if (state == IDLE && start) begin
      map_k   = '0;
      map_res = freq_res;
    end else if (freq_step_ack) begin
      map_k = k + 1'b1;
    end
  end

  assign map_d = ow'(map_k) - centre_w;

  caf_foa_step_map #(
    .phase_bits (phase_bits),
    .d_bits     (ow)
  ) u_step_map (
    .d         (map_d),
    .freq_res  (map_res),
    .freq_step (map_step),
    .neg_shift (map_neg)
  );

  // Sequencer: load bins, hand over the last bin, collect and hold the CAF result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      k               <= '0;
      res_q           <= '0;
      busy            <= 1'b0;
      freq_step       <= '0;
      neg_shift       <= 1'b0;
      freq_step_valid <= 1'b0;
      res_tready      <= 1'b0;
      result_valid    <= 1'b0;
      result_max      <= '0;
      result_foa      <= '0;
      result_lag      <= '0;
      index_err       <= 1'b0;
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
      wd_cnt          <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            res_q           <= freq_res;
            k               <= '0;
            index_err       <= 1'b0;
            freq_step       <= map_step;
            neg_shift       <= map_neg;
            freq_step_valid <= 1'b1;
            busy            <= 1'b1;
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
            timeout_err     <= 1'b0;
`endif
            state           <= (foas == 1) ? LAST : LOAD;
          end
        end
        LOAD: begin
          if (freq_step_ack) begin
            k         <= k + 1'b1;
            freq_step <= map_step;
            neg_shift <= map_neg;
            if (caf_step_index != k) index_err <= 1'b1;
            if (k + 1'b1 == last_k) state <= LAST;
          end
        end
        LAST: begin
          // The CAF takes its final bin without a ready, so this lasts one cycle
          if (caf_step_index != last_k) index_err <= 1'b1;
          freq_step_valid <= 1'b0;
          res_tready      <= 1'b1;
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
          wd_cnt          <= '0;
`endif
          state           <= WAIT_RES;
        end
        WAIT_RES: begin
          if (res_tvalid && res_tready) begin
            result_max   <= caf_out_max;
            result_lag   <= caf_time_index;
            result_foa   <= ow'(caf_foas_index) - centre_w;
            res_tready   <= 1'b0;
            result_valid <= 1'b1;
            state        <= OUTPUT;
          end
`ifdef CAF_FOA_SEQ_TIMEOUT_EN
          else if (wd_cnt == tw'(timeout_cycles - 1)) begin
            timeout_err <= 1'b1;
            res_tready  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/caf_foa_sequencer.md
Name: caf_foa_sequencer

Overview:
- Upstream controller for the CAF top: programs the frequency-offset (FOA) bank and consumes the CAF's peak result.
- On start, generates a symmetric set of frequency steps centred on zero Doppler.
- Delivers the steps over the CAF freq-step handshake, then waits for the CAF result stream.
- Converts the winning bin index into a signed FOA offset for the host.

Parameters:
- phase_bits, 10, width of freq_step and freq_res
- foas, 3, number of FOA bins; odd, at least 1
- foas_counter_bits, 3, width of FOA indices; 2**foas_counter_bits must be at least foas
- length_counter_bits, 3, width of the CAF time index
- out_max_bits, 64, width of the CAF peak magnitude

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle request; ignored unless idle
- freq_res  in  phase_bits  step per bin; sampled on accepted start
- busy  out  1  high in every state except IDLE
- freq_step  out  phase_bits  magnitude of the current bin's step
- neg_shift  out  1  current bin is negative
- freq_step_valid  out  1  drives the CAF s_axis_freq_step_valid
- freq_step_ack  out  1  drives the CAF s_axis_freq_step_tready
- caf_step_ready  in  1  from the CAF m_axis_freq_step_tready
- caf_step_index  in  foas_counter_bits  from the CAF freq_step_index
- res_tvalid  in  1  from the CAF s_axis_tvalid
- res_tready  out  1  drives the CAF m_axis_tready
- caf_out_max  in  out_max_bits  peak magnitude
- caf_foas_index  in  foas_counter_bits  winning bin
- caf_time_index  in  length_counter_bits  winning lag
- result_valid  out  1  result held until result_ready
- result_ready  in  1  host accept
- result_max  out  out_max_bits  captured peak magnitude
- result_foa  out  foas_counter_bits+1  signed offset, winning bin minus centre
- result_lag  out  length_counter_bits  captured lag
- index_err  out  1  sticky index-mismatch flag; cleared on accepted start

Behaviour:
- Reset: all outputs are 0 and the state is IDLE.
- States are IDLE, LOAD, LAST, WAIT_RES, OUTPUT.
- IDLE to LOAD: on start. Registers freq_res and clears bin counter k and index_err.
- Step mapping: C = (foas-1)/2 and d = k - C.
  - freq_step = |d| * freq_res, truncated to phase_bits (modulo wrap, no saturation).
  - neg_shift = (d < 0).
  - Both outputs are registered and update the cycle after k changes.
- LOAD: freq_step_valid = 1.
  - freq_step_ack = caf_step_ready & freq_step_valid.
  - On ack, k increments.
  - If caf_step_index != k at the ack cycle, index_err is set.
- LOAD to LAST: when k reaches foas-1.
- LAST: presents bin foas-1 with freq_step_valid high for exactly one cycle and ack low; the CAF accepts its last bin without a ready.
  - If caf_step_index != foas-1 in that cycle, index_err is set.
  - Next state is WAIT_RES.
- foas = 1: LOAD is skipped; IDLE goes straight to LAST.
- WAIT_RES: res_tready = 1; res_tready is 0 in all other states.
  - When res_tvalid & res_tready, captures result_max, result_lag, and result_foa = caf_foas_index - C (sign-extended), then goes to OUTPUT.
- OUTPUT: result_valid = 1 and the result registers are stable.
  - On result_ready, drops result_valid and returns to IDLE.
  - Same-cycle start is ignored; start is accepted from IDLE only.
- start while busy: ignored; freq_res is not resampled.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. The CAF must be reset alongside.
- Latency: start to first freq_step_valid is 1 cycle. Capture to result_valid is 1 cycle.

Optional Feature:
- Macro: CAF_FOA_SEQ_TIMEOUT_EN.
- Enabled:
  - Adds parameter timeout_cycles (default 4096), a WAIT_RES watchdog counter, and output timeout_err (1 bit, sticky, cleared on accepted start).
  - The counter reaching timeout_cycles-1 without a capture sets timeout_err and forces IDLE without asserting result_valid.
- Disabled: no counter or port; WAIT_RES waits indefinitely.

Decomposition:
- Shared package caf_pkg holds:
  - state encodings: IDLE 3'd0, LOAD 3'd1, LAST 3'd2, WAIT_RES 3'd3, OUTPUT 3'd4;
  - the centre-bin function (foas-1)/2;
  - the signed-offset width rule, foas_counter_bits+1.
- One sub-module: caf_foa_step_map, a combinational d to (|d|*freq_res, sign) mapper reused by the CAF reference model.

Test Plan:
- foas=5, freq_res=12, caf_step_ready always 1, index tracking: steps (24,neg), (12,neg), (0,+), (12,+), (24,+); valid held one cycle on bin 4; index_err stays 0.
- Same as the first case, but caf_step_ready low 3 cycles before each ack: k holds and freq_step is stable while stalled; the same step sequence results.
- CAF returns caf_foas_index=1, caf_out_max=0x1234, lag=6 with foas=5: result_foa=-1 (4'b1111), result_max=0x1234, result_lag=6; result_valid is held through 4 cycles of result_ready=0.
- caf_step_index stuck at 0 during LOAD: index_err=1 after the second ack; the next accepted start clears it.
- rst_n pulsed low mid-LOAD at k=2: all outputs 0 asynchronously; a fresh start replays from bin 0.
- With CAF_FOA_SEQ_TIMEOUT_EN and timeout_cycles=16, res_tvalid never asserts: timeout_err=1 after 16 WAIT_RES cycles, state IDLE, result_valid never rises.
